// File: rtl/wb_regfile.sv
// wb_regfile
//   Write-back end of the MEM/WB boundary. Selects the write-back value from
//   the registered WB bundle, retires it into the architectural register
//   file, serves the two ID-stage read ports with write-through bypass, and
//   streams every register out over a backpressured dump port for debug.
//
// Ports
//   i_clk, i_reset_n        clock (rising edge), asynchronous active-low reset
//   i_wb_data               memory read data from the WB bundle
//   i_wb_alu_result         ALU result from the WB bundle
//   i_wb_rd                 destination register index
//   i_wb_mem_to_reg         1 = retire i_wb_data, 0 = retire i_wb_alu_result
//   i_wb_reg_write          write enable from the WB bundle
//   i_rs_addr, i_rt_addr    read port indices
//   o_rs_data, o_rt_data    read port data (combinational, bypassed)
//   o_wb_write_data         selected write-back value, for forwarding
//   i_dump_start            single-cycle request to begin a dump
//   i_dump_ready            consumer accepts the current dump beat
//   o_dump_valid            dump beat valid
//   o_dump_addr             register index of the current beat
//   o_dump_data             register value of the current beat
//   o_dump_last             current beat is the final register
//   o_dump_busy             dump in progress
`timescale 1ns/1ps

module wb_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [DATA_WIDTH-1:0] i_wb_data,
  input  logic [DATA_WIDTH-1:0] i_wb_alu_result,
  input  logic [ADDR_WIDTH-1:0] i_wb_rd,
  input  logic                  i_wb_mem_to_reg,
  input  logic                  i_wb_reg_write,
  input  logic [ADDR_WIDTH-1:0] i_rs_addr,
  input  logic [ADDR_WIDTH-1:0] i_rt_addr,
  output logic [DATA_WIDTH-1:0] o_rs_data,
  output logic [DATA_WIDTH-1:0] o_rt_data,
  output logic [DATA_WIDTH-1:0] o_wb_write_data,
  input  logic                  i_dump_start,
  input  logic                  i_dump_ready,
  output logic                  o_dump_valid,
  output logic [ADDR_WIDTH-1:0] o_dump_addr,
  output logic [DATA_WIDTH-1:0] o_dump_data,
  output logic                  o_dump_last,
  output logic                  o_dump_busy
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_REGS - 1);

  typedef enum logic {
    IDLE,
    SEND
  } dump_state_t;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic                  we;

  dump_state_t           state;
  dump_state_t           next_state;
  logic [ADDR_WIDTH-1:0] dump_addr;
  logic [DATA_WIDTH-1:0] dump_data;
  logic                  at_last;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [DATA_WIDTH-1:0] next_data;

  assign o_wb_write_data = i_wb_mem_to_reg ? i_wb_data : i_wb_alu_result;

  // r0 is hardwired to zero, so a write aimed at it is dropped here
  assign we = i_wb_reg_write && (i_wb_rd != '0);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[i_wb_rd] <= o_wb_write_data;
    end
  end

  // Reads are forced to zero while reset is held, so a bypass hit cannot leak
  // a stale WB bundle out during reset
  always_comb begin
    o_rs_data = regs[i_rs_addr];
    if (!i_reset_n || (i_rs_addr == '0)) begin
      o_rs_data = '0;
    end else if (we && (i_rs_addr == i_wb_rd)) begin
      o_rs_data = o_wb_write_data;
    end
  end

  always_comb begin
    o_rt_data = regs[i_rt_addr];
    if (!i_reset_n || (i_rt_addr == '0)) begin
      o_rt_data = '0;
    end else if (we && (i_rt_addr == i_wb_rd)) begin
      o_rt_data = o_wb_write_data;
    end
  end

  assign at_last   = (dump_addr == LAST_ADDR);
  assign next_addr = dump_addr + ADDR_WIDTH'(1);

  // The next beat must carry the post-edge register value, so a write landing
  // on the accepting edge is bypassed into the dump data register
  assign next_data = (we && (i_wb_rd == next_addr)) ? o_wb_write_data
                                                    : regs[next_addr];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (i_dump_start) next_state = SEND;
      SEND:    if (i_dump_ready && at_last) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Beat register: loads r0 on start, advances on accept, and returns to zero
  // after the final beat; a stalled beat keeps its captured data
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      dump_addr <= '0;
      dump_data <= '0;
    end else if ((state == IDLE) && i_dump_start) begin
      dump_addr <= '0;
      dump_data <= '0;
    end else if ((state == SEND) && i_dump_ready) begin
      if (at_last) begin
        dump_addr <= '0;
        dump_data <= '0;
      end else begin
        dump_addr <= next_addr;
        dump_data <= next_data;
      end
    end
  end

  always_comb begin
    o_dump_valid = (state == SEND);
    o_dump_busy  = (state == SEND);
    o_dump_last  = (state == SEND) && at_last;
    o_dump_addr  = dump_addr;
    o_dump_data  = dump_data;
  end

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile
//   Directed bench for wb_regfile: write-back mux, r0 handling, read bypass,
//   and two dumps (free-flowing, then stalled / overwritten / reset mid-way).
//   Dump beats are predicted from a register model into a scoreboard queue.
`timescale 1ns/1ps

module tb_wb_regfile;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic        i_clk;
  logic        i_reset_n;
  logic [31:0] i_wb_data;
  logic [31:0] i_wb_alu_result;
  logic [4:0]  i_wb_rd;
  logic        i_wb_mem_to_reg;
  logic        i_wb_reg_write;
  logic [4:0]  i_rs_addr;
  logic [4:0]  i_rt_addr;
  logic [31:0] o_rs_data;
  logic [31:0] o_rt_data;
  logic [31:0] o_wb_write_data;
  logic        i_dump_start;
  logic        i_dump_ready;
  logic        o_dump_valid;
  logic [4:0]  o_dump_addr;
  logic [31:0] o_dump_data;
  logic        o_dump_last;
  logic        o_dump_busy;

  int          checks;
  int          failures;
  logic [31:0] model [32];
  beat_t       sb_q [$];

  wb_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .i_clk           (i_clk),
    .i_reset_n       (i_reset_n),
    .i_wb_data       (i_wb_data),
    .i_wb_alu_result (i_wb_alu_result),
    .i_wb_rd         (i_wb_rd),
    .i_wb_mem_to_reg (i_wb_mem_to_reg),
    .i_wb_reg_write  (i_wb_reg_write),
    .i_rs_addr       (i_rs_addr),
    .i_rt_addr       (i_rt_addr),
    .o_rs_data       (o_rs_data),
    .o_rt_data       (o_rt_data),
    .o_wb_write_data (o_wb_write_data),
    .i_dump_start    (i_dump_start),
    .i_dump_ready    (i_dump_ready),
    .o_dump_valid    (o_dump_valid),
    .o_dump_addr     (o_dump_addr),
    .o_dump_data     (o_dump_data),
    .o_dump_last     (o_dump_last),
    .o_dump_busy     (o_dump_busy)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic we, input logic m2r, input logic [4:0] rd,
                                input logic [31:0] alu, input logic [31:0] mem);
    i_wb_reg_write  = we;
    i_wb_mem_to_reg = m2r;
    i_wb_rd         = rd;
    i_wb_alu_result = alu;
    i_wb_data       = mem;
  endtask

  task automatic check_dump_idle(input string tag);
    check_output({tag, "_valid"}, 32'(o_dump_valid), 32'd0);
    check_output({tag, "_busy"},  32'(o_dump_busy),  32'd0);
    check_output({tag, "_last"},  32'(o_dump_last),  32'd0);
    check_output({tag, "_addr"},  32'(o_dump_addr),  32'd0);
    check_output({tag, "_data"},  o_dump_data,       32'd0);
  endtask

  // Called at a negedge. scenario=0: free-flowing dump with a stray start
  // pulse mid-way. scenario=1: stall at beat 10 while overwriting r10, write
  // r11 on the accepting edge, reset at beat 20.
  task automatic run_dump(input bit scenario);
    int    stalls = 0;
    int    cycles = 0;
    bit    done = 0;
    bit    accept;
    int    pend_rd;
    logic [31:0] pend_val;
    beat_t b;
    logic [4:0] na;
    sb_q.delete();
    sb_q.push_back('{addr: 5'd0, data: 32'd0, last: 1'b0});
    i_dump_start = 1'b1;
    i_dump_ready = 1'b1;
    @(negedge i_clk);
    i_dump_start = 1'b0;
    while (!done) begin
      cycles++;
      if (cycles > 100 || sb_q.size() == 0) begin
        checks++;
        failures++;
        $error("[TB] FAIL dump_timeout: observed=cycles %0d required=complete dump", cycles);
        break;
      end
      b = sb_q[0];
      check_output("dump_valid", 32'(o_dump_valid), 32'd1);
      check_output("dump_busy",  32'(o_dump_busy),  32'd1);
      check_output("dump_addr",  32'(o_dump_addr),  32'(b.addr));
      check_output("dump_data",  o_dump_data,       b.data);
      check_output("dump_last",  32'(o_dump_last),  32'(b.last));
      accept       = 1'b1;
      pend_rd      = 0;
      pend_val     = '0;
      i_dump_start = (!scenario && b.addr == 5'd5);
      apply_stimulus(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
      if (scenario && b.addr == 5'd20) begin
        i_rs_addr = 5'd10;
        i_rt_addr = 5'd11;
        i_reset_n = 1'b0;
        #1;
        check_dump_idle("reset_mid_dump");
        check_output("reset_mid_rs", o_rs_data, 32'd0);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        foreach (model[k]) model[k] = '0;
        #1;
        check_output("post_reset_r10", o_rs_data, model[10]);
        check_output("post_reset_r11", o_rt_data, model[11]);
        check_dump_idle("post_reset_dump");
        done = 1;
      end else begin
        if (scenario && b.addr == 5'd10 && stalls < 4) begin
          accept = 1'b0;
          if (stalls == 1) begin
            apply_stimulus(1'b1, 1'b0, 5'd10, 32'h0000AAAA, 32'd0);
            pend_rd  = 10;
            pend_val = 32'h0000AAAA;
          end
          stalls++;
        end else if (scenario && b.addr == 5'd10) begin
          apply_stimulus(1'b1, 1'b0, 5'd11, 32'h0000BBBB, 32'd0);
          pend_rd  = 11;
          pend_val = 32'h0000BBBB;
        end
        i_dump_ready = accept;
        @(posedge i_clk);
        if (pend_rd != 0) model[pend_rd] = pend_val;
        if (accept) begin
          void'(sb_q.pop_front());
          if (b.last) begin
            done = 1;
          end else begin
            na = b.addr + 5'd1;
            sb_q.push_back('{addr: na, data: model[na], last: (na == 5'd31)});
          end
        end
        @(negedge i_clk);
      end
    end
    i_dump_start = 1'b0;
    i_dump_ready = 1'b1;
    apply_stimulus(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    foreach (model[k]) model[k] = '0;
    i_reset_n    = 1'b0;
    i_dump_start = 1'b0;
    i_dump_ready = 1'b0;
    i_rs_addr    = 5'd3;
    i_rt_addr    = 5'd0;
    apply_stimulus(1'b1, 1'b0, 5'd3, 32'h55555555, 32'd0);

    // Reset state, including a pending write that must not bypass
    @(negedge i_clk);
    #1;
    check_dump_idle("reset");
    check_output("reset_rs_bypass", o_rs_data, 32'd0);
    @(negedge i_clk);
    apply_stimulus(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    i_reset_n = 1'b1;
    @(negedge i_clk);

    for (int i = 0; i < 32; i++) begin
      i_rs_addr = 5'(i);
      i_rt_addr = 5'(31 - i);
      #1;
      check_output("reset_read_rs", o_rs_data, 32'd0);
      check_output("reset_read_rt", o_rt_data, 32'd0);
    end

    // ALU result write, read back next cycle
    @(negedge i_clk);
    apply_stimulus(1'b1, 1'b0, 5'd5, 32'h12345678, 32'h0BADF00D);
    #1;
    check_output("wb_mux_alu", o_wb_write_data, 32'h12345678);
    @(posedge i_clk);
    model[5] = 32'h12345678;
    @(negedge i_clk);
    apply_stimulus(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    i_rs_addr = 5'd5;
    #1;
    check_output("read_r5", o_rs_data, model[5]);

    // Memory data write
    @(negedge i_clk);
    apply_stimulus(1'b1, 1'b1, 5'd7, 32'h00000001, 32'hDEADBEEF);
    #1;
    check_output("wb_mux_mem", o_wb_write_data, 32'hDEADBEEF);
    @(posedge i_clk);
    model[7] = 32'hDEADBEEF;
    @(negedge i_clk);
    apply_stimulus(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    i_rt_addr = 5'd7;
    #1;
    check_output("read_r7", o_rt_data, model[7]);

    // Bypass: disabled write shows the old value, enabled write bypasses
    @(negedge i_clk);
    i_rs_addr = 5'd9;
    i_rt_addr = 5'd9;
    apply_stimulus(1'b0, 1'b0, 5'd9, 32'hCAFE0001, 32'd0);
    #1;
    check_output("nobypass_rs", o_rs_data, 32'd0);
    check_output("nobypass_wbdata", o_wb_write_data, 32'hCAFE0001);
    apply_stimulus(1'b1, 1'b0, 5'd9, 32'hCAFE0001, 32'd0);
    #1;
    check_output("bypass_rs", o_rs_data, 32'hCAFE0001);
    check_output("bypass_rt", o_rt_data, 32'hCAFE0001);
    @(posedge i_clk);
    model[9] = 32'hCAFE0001;
    @(negedge i_clk);
    apply_stimulus(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    #1;
    check_output("read_r9", o_rs_data, model[9]);

    // r0 write is discarded and never bypassed
    @(negedge i_clk);
    i_rs_addr = 5'd0;
    i_rt_addr = 5'd0;
    apply_stimulus(1'b1, 1'b0, 5'd0, 32'hFFFFFFFF, 32'd0);
    #1;
    check_output("r0_during_write", o_rs_data, 32'd0);
    @(posedge i_clk);
    @(negedge i_clk);
    apply_stimulus(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    #1;
    check_output("r0_after_write", o_rt_data, 32'd0);

    // Preload reg[k] = k*3
    for (int k = 1; k < 32; k++) begin
      @(negedge i_clk);
      apply_stimulus(1'b1, 1'b0, 5'(k), 32'(k * 3), 32'd0);
      @(posedge i_clk);
      model[k] = 32'(k * 3);
    end
    @(negedge i_clk);
    apply_stimulus(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);

    run_dump(1'b0);
    #1;
    check_dump_idle("after_dump");

    @(negedge i_clk);
    run_dump(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
